// File: rtl/match_scheduler.sv
// match_scheduler: walks every POI placement inside the ROI in raster order, issues offset commands
// to the SAD datapath and keeps the lowest returned score. Optional macro: MATCH_SCHED_EARLY_EXIT_EN.
module match_scheduler #(
  parameter int ROI_DEPTH = 6,
  parameter int ROI_WIDTH = 6,
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4,
  parameter int SCORE_W   = 16,
  parameter int MAX_OUT   = 4,
  parameter int OFF_W     = ($clog2((ROI_DEPTH > ROI_WIDTH) ? ROI_DEPTH : ROI_WIDTH) < 1) ? 1 :
                            $clog2((ROI_DEPTH > ROI_WIDTH) ? ROI_DEPTH : ROI_WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               status,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [OFF_W-1:0]   cmd_row,
  output logic [OFF_W-1:0]   cmd_col,
  output logic               cmd_last,
  input  logic               rsp_valid,
  input  logic [SCORE_W-1:0] rsp_score,
  output logic [OFF_W-1:0]   best_row,
  output logic [OFF_W-1:0]   best_col,
  output logic [SCORE_W-1:0] best_score
);

  localparam int               CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [OFF_W-1:0] ROW_MAX = OFF_W'(ROI_DEPTH - POI_DEPTH);
  localparam logic [OFF_W-1:0] COL_MAX = OFF_W'(ROI_WIDTH - POI_WIDTH);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_status;
  logic               r_cmd_valid;
  logic [OFF_W-1:0]   r_cmd_row;
  logic [OFF_W-1:0]   r_cmd_col;
  logic               r_cmd_last;
  logic [OFF_W-1:0]   r_rsp_row;
  logic [OFF_W-1:0]   r_rsp_col;
  logic [CNT_W-1:0]   r_out;
  logic [OFF_W-1:0]   r_best_row;
  logic [OFF_W-1:0]   r_best_col;
  logic [SCORE_W-1:0] r_best_score;

  logic               w_xfer;
  logic               w_rsp_acc;
  logic               w_better;
  logic               w_zero_hit;
  logic               w_stop;
  logic [CNT_W-1:0]   w_out_next;
  logic [OFF_W-1:0]   w_cmd_row_nx;
  logic [OFF_W-1:0]   w_cmd_col_nx;
  logic [OFF_W-1:0]   w_rsp_row_nx;
  logic [OFF_W-1:0]   w_rsp_col_nx;

  function automatic logic is_final(input logic [OFF_W-1:0] row, input logic [OFF_W-1:0] col);
    return (row == ROW_MAX) && (col == COL_MAX);
  endfunction

  // Column runs fastest; wrapping the column carries into the row.
  function automatic logic [2*OFF_W-1:0] raster_next(input logic [OFF_W-1:0] row,
                                                     input logic [OFF_W-1:0] col);
    if (col == COL_MAX) begin
      return {row + OFF_W'(1), {OFF_W{1'b0}}};
    end
    return {row, col + OFF_W'(1)};
  endfunction

  always_comb begin
    w_xfer     = r_cmd_valid & cmd_ready;
    // Responses with nothing outstanding are leftovers from an aborted scan.
    w_rsp_acc  = rsp_valid & ((r_state == S_ISSUE) | (r_state == S_DRAIN)) & (r_out != '0);
    w_better   = w_rsp_acc & (rsp_score < r_best_score);
    w_out_next = r_out + CNT_W'(w_xfer) - CNT_W'(w_rsp_acc);
`ifdef MATCH_SCHED_EARLY_EXIT_EN
    w_zero_hit = w_rsp_acc & (r_state == S_ISSUE) & (rsp_score == '0);
`else
    w_zero_hit = 1'b0;
`endif
    w_stop     = (r_state == S_ISSUE) & ((w_xfer & r_cmd_last) | w_zero_hit);
    {w_cmd_row_nx, w_cmd_col_nx} = raster_next(r_cmd_row, r_cmd_col);
    {w_rsp_row_nx, w_rsp_col_nx} = raster_next(r_rsp_row, r_rsp_col);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_row    <= '0;
      r_cmd_col    <= '0;
      r_cmd_last   <= 1'b0;
      r_rsp_row    <= '0;
      r_rsp_col    <= '0;
      r_out        <= '0;
      r_best_row   <= '0;
      r_best_col   <= '0;
      r_best_score <= '0;
    end else begin
      r_done <= 1'b0;
      r_out  <= w_out_next;

      if (w_rsp_acc) begin
        r_rsp_row <= w_rsp_row_nx;
        r_rsp_col <= w_rsp_col_nx;
      end
      if (w_better) begin
        r_best_score <= rsp_score;
        r_best_row   <= r_rsp_row;
        r_best_col   <= r_rsp_col;
      end

      if (w_xfer && !r_cmd_last) begin
        r_cmd_row  <= w_cmd_row_nx;
        r_cmd_col  <= w_cmd_col_nx;
        r_cmd_last <= is_final(w_cmd_row_nx, w_cmd_col_nx);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_ISSUE;
            r_busy       <= 1'b1;
            r_status     <= 1'b0;
            r_cmd_valid  <= 1'b1;
            r_cmd_row    <= '0;
            r_cmd_col    <= '0;
            r_cmd_last   <= is_final('0, '0);
            r_rsp_row    <= '0;
            r_rsp_col    <= '0;
            r_out        <= '0;
            r_best_row   <= '0;
            r_best_col   <= '0;
            r_best_score <= '1;
          end
        end
        S_ISSUE: begin
          if (w_stop) begin
            r_cmd_valid <= 1'b0;
            r_cmd_last  <= 1'b0;
            if (w_out_next == '0) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_status <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_cmd_valid <= (w_out_next < OUT_MAX);
          end
        end
        S_DRAIN: begin
          if (w_out_next == '0) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_status <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign status     = r_status;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_row    = r_cmd_row;
  assign cmd_col    = r_cmd_col;
  assign cmd_last   = r_cmd_last;
  assign best_row   = r_best_row;
  assign best_col   = r_best_col;
  assign best_score = r_best_score;

endmodule

// File: tb/tb_match_scheduler.sv
// Bench for match_scheduler: table of directed scans, reset/idle corner sequences and random scans
// checked against an argmin reference over the scores of the commands actually issued.
module tb_match_scheduler;

  localparam int RD = 6, RW = 6, PD = 4, PW = 4, SW = 16, MAXO = 4;
  localparam int NR = RD - PD + 1;
  localparam int NC = RW - PW + 1;
  localparam int N  = NR * NC;
  localparam int OW = 3;
  localparam int LIMIT = 600;

  logic          clk = 1'b0;
  logic          reset, start, cmd_ready, rsp_valid;
  logic [SW-1:0] rsp_score;
  logic          busy, done, status, cmd_valid, cmd_last;
  logic [OW-1:0] cmd_row, cmd_col, best_row, best_col;
  logic [SW-1:0] best_score;

  always #5 clk = ~clk;

  match_scheduler #(
    .ROI_DEPTH(RD), .ROI_WIDTH(RW), .POI_DEPTH(PD), .POI_WIDTH(PW),
    .SCORE_W(SW), .MAX_OUT(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .status(status),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_last(cmd_last), .rsp_valid(rsp_valid), .rsp_score(rsp_score),
    .best_row(best_row), .best_col(best_col), .best_score(best_score)
  );

  typedef struct packed {
    logic [8:0][15:0] sc;
    logic [7:0]       lat;
    logic [7:0]       rdy;
    logic             b2b;
    logic [2:0]       erow;
    logic [2:0]       ecol;
    logic [15:0]      escore;
  } vec_t;

  vec_t vecs[6];
  int   t[9];
  int   scores[N];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rst_outs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_row", int'(cmd_row), 0);
    chk("rst_cmd_col", int'(cmd_col), 0);
    chk("rst_cmd_last", int'(cmd_last), 0);
    chk("rst_best_row", int'(best_row), 0);
    chk("rst_best_col", int'(best_col), 0);
    chk("rst_best_score", int'(best_score), 0);
  endtask

  // Reference: first strictly-smallest score among the first n issued placements.
  function automatic void model_best(input int n, output int r, output int c, output int s);
    s = 'hFFFF; r = 0; c = 0;
    for (int i = 0; i < n; i++) begin
      if (scores[i] < s) begin
        s = scores[i]; r = i / NC; c = i % NC;
      end
    end
  endfunction

  task automatic put(input int i, input int lat, input int rdy, input bit b2b,
                     input int er, input int ec, input int es);
    for (int j = 0; j < 9; j++) vecs[i].sc[j] = 16'(t[j]);
    vecs[i].lat    = 8'(lat);
    vecs[i].rdy    = 8'(rdy);
    vecs[i].b2b    = b2b;
    vecs[i].erow   = 3'(er);
    vecs[i].ecol   = 3'(ec);
    vecs[i].escore = 16'(es);
  endtask

  task automatic check_issued(input int issued);
    int fz;
    fz = -1;
    for (int i = N - 1; i >= 0; i--) if (scores[i] == 0) fz = i;
`ifdef MATCH_SCHED_EARLY_EXIT_EN
    if (fz < 0) chk("issued_all", issued, N);
    else chk("issued_past_zero", int'(issued > fz && issued <= N), 1);
`else
    chk("issued_all", issued, N);
`endif
  endtask

  task automatic run_scan(input int lat, input int rdy, input int rst_at,
                          output int issued, output int last_xfer);
    int pidx[$];
    int pdue[$];
    int idx, outst, last_rsp, er, ec, es;
    bit ee_stop, fin;
    idx = 0; outst = 0; last_rsp = -100; ee_stop = 0; fin = 0; last_xfer = -1;
    @(negedge clk);
    start = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_valid", int'(cmd_valid), 1);
    chk("start_status", int'(status), 0);
    for (int cyc = 0; cyc < LIMIT && !fin; cyc++) begin
      if (done) begin
        model_best(idx, er, ec, es);
        chk("done_latency", cyc, last_rsp + 1);
        chk("done_busy", int'(busy), 0);
        chk("done_status", int'(status), 1);
        chk("done_best_row", int'(best_row), er);
        chk("done_best_col", int'(best_col), ec);
        chk("done_best_score", int'(best_score), es);
        start = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0;
        fin = 1'b1;
      end else begin
        if (ee_stop) chk("ee_valid_drop", int'(cmd_valid), 0);
        if (cmd_valid) begin
          chk("extra_cmd", int'(idx < N), 1);
          chk("outst_limit", int'(outst < MAXO), 1);
          chk("cmd_row", int'(cmd_row), idx / NC);
          chk("cmd_col", int'(cmd_col), idx % NC);
          chk("cmd_last", int'(cmd_last), int'(idx == N - 1));
        end
        if (rst_at >= 0 && cmd_valid && idx == rst_at) begin
          reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
          #1;
          chk_rst_outs();
          @(negedge clk);
          reset = 1'b0;
          for (int k = 0; k < 8; k++) begin
            rsp_valid = (pidx.size() > 0);
            rsp_score = '0;
            if (pidx.size() > 0) begin
              void'(pidx.pop_front());
              void'(pdue.pop_front());
            end
            @(negedge clk);
            chk("stale_busy", int'(busy), 0);
          end
          rsp_valid = 1'b0;
          chk_rst_outs();
          fin = 1'b1;
        end else begin
          start     = (cyc == 2);
          cmd_ready = (int'($urandom_range(99)) < rdy);
          if (cmd_valid && cmd_ready) begin
            pidx.push_back(idx);
            pdue.push_back(cyc + lat);
            idx++; outst++;
            last_xfer = cyc;
          end
          rsp_valid = 1'b0;
          if (pdue.size() > 0 && pdue[0] == cyc) begin
            rsp_valid = 1'b1;
            rsp_score = SW'(scores[pidx[0]]);
`ifdef MATCH_SCHED_EARLY_EXIT_EN
            if (scores[pidx[0]] == 0 && idx < N) ee_stop = 1'b1;
`endif
            void'(pidx.pop_front());
            void'(pdue.pop_front());
            outst--;
            last_rsp = cyc;
          end
          @(negedge clk);
        end
      end
    end
    if (!fin) chk("scan_timeout", 0, 1);
    start = 1'b0; rsp_valid = 1'b0;
    issued = idx;
  endtask

  task automatic post_done(input int er, input int ec, input int es);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("status_hold", int'(status), 1);
    chk("hold_best_row", int'(best_row), er);
    chk("hold_best_col", int'(best_col), ec);
    chk("hold_best_score", int'(best_score), es);
  endtask

  initial begin
    int issued, lx, er, ec, es;
    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_score = '0;
    repeat (3) @(negedge clk);
    chk_rst_outs();
    reset = 1'b0;

    t = '{9, 8, 7, 6, 5, 4, 3, 2, 1};                   put(0, 2, 100, 1, 2, 2, 1);
    t = '{5, 5, 5, 5, 5, 5, 5, 5, 5};                   put(1, 3, 100, 0, 0, 0, 5);
    t = '{4, 6, 0, 2, 7, 3, 8, 1, 9};                   put(2, 2, 100, 0, 0, 2, 0);
    t = '{30, 12, 40, 12, 50, 60, 12, 70, 80};          put(3, 4, 50, 0, 0, 1, 12);
    t = '{50, 50, 50, 50, 50, 50, 3, 50, 3};            put(4, 1, 70, 0, 2, 0, 3);
    t = '{'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF};
    put(5, 3, 100, 0, 0, 0, 'hFFFF);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < N; j++) scores[j] = int'(vecs[i].sc[j]);
      run_scan(int'(vecs[i].lat), int'(vecs[i].rdy), -1, issued, lx);
      check_issued(issued);
      if (vecs[i].b2b) chk("b2b_last_xfer", lx, N - 1);
`ifdef MATCH_SCHED_EARLY_EXIT_EN
      if (i == 2) chk("ee_cut_short", int'(issued < N), 1);
`endif
      post_done(int'(vecs[i].erow), int'(vecs[i].ecol), int'(vecs[i].escore));
    end

    // Responses while idle must not touch the held result.
    rsp_valid = 1'b1; rsp_score = '0;
    repeat (3) @(negedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_rsp_score", int'(best_score), 'hFFFF);
    chk("idle_rsp_busy", int'(busy), 0);
    chk("idle_rsp_status", int'(status), 1);

    for (int j = 0; j < N; j++) scores[j] = 10 + j;
    run_scan(4, 100, 4, issued, lx);
    t = '{20, 15, 18, 15, 11, 19, 11, 13, 17};
    for (int j = 0; j < N; j++) scores[j] = t[j];
    run_scan(3, 80, -1, issued, lx);
    check_issued(issued);
    post_done(1, 1, 11);

    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < N; j++) scores[j] = int'($urandom_range(20));
      run_scan(int'($urandom_range(5, 1)), int'($urandom_range(100, 30)), -1, issued, lx);
      check_issued(issued);
      model_best(issued, er, ec, es);
      post_done(er, ec, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
